// File: rtl/mem_addr_sequencer.sv
// mem_addr_sequencer: memory address mux with exception vector fetch; optional EXC_PENDING_EN queues requests
module mem_addr_sequencer #(
  parameter int DATA_W = 32,
  parameter int N_SRC = 3,
  parameter int N_EXC = 3,
  parameter int VEC_BASE = 253,
  parameter int MEM_LAT = 1,
  parameter int SEL_W = $clog2(N_SRC),
  parameter int EXC_W = (N_EXC > 1) ? $clog2(N_EXC) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [SEL_W-1:0]        src_sel,
  input  logic [N_SRC*DATA_W-1:0] src_bus,
  input  logic [N_EXC-1:0]        exc_req,
  input  logic [DATA_W-1:0]       mem_rdata,
  output logic [DATA_W-1:0]       mem_addr,
  output logic                    busy,
  output logic                    vec_valid,
  output logic [DATA_W-1:0]       vec_addr,
  output logic [EXC_W-1:0]        exc_code
);
  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [1:0] IDLE = 2'd0, FETCH = 2'd1, DONE = 2'd2;
  logic [1:0] state;
  logic [CNT_W-1:0] cnt;
  logic [N_EXC-1:0] req, win;
  logic [EXC_W-1:0] win_idx;
  logic [DATA_W-1:0] pass;
  logic start, unused;
  assign unused = ^mem_rdata;
`ifdef EXC_PENDING_EN
  logic [N_EXC-1:0] pending;
  // remember every request; the one being served is retired as its fetch starts
  always_ff @(posedge clk)
    if (reset) pending <= '0;
    else pending <= (pending | exc_req) & ~(start ? win : '0);
  assign req = exc_req | pending;
`else
  assign req = exc_req;
`endif
  // lowest set index wins: scan downwards so the last hit is the smallest
  always_comb begin
    win = '0;
    win_idx = '0;
    for (int i = N_EXC - 1; i >= 0; i--)
      if (req[i]) begin
        win = '0;
        win[i] = 1'b1;
        win_idx = EXC_W'(i);
      end
  end
  // normal-mode source mux; out-of-range selects give zero
  always_comb begin
    pass = '0;
    for (int i = 0; i < N_SRC; i++)
      if (src_sel == SEL_W'(i)) pass = src_bus[i*DATA_W +: DATA_W];
  end
  assign start = (state == IDLE) && |req;
  assign mem_addr = (state == IDLE) ? pass : DATA_W'(VEC_BASE) + DATA_W'(exc_code);
  assign busy = state != IDLE;
  assign vec_valid = state == DONE;
  // fetch sequencing: wait MEM_LAT cycles on the vector address, capture the handler byte
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      vec_addr <= '0;
      exc_code <= '0;
    end else if (start) begin
      state <= FETCH;
      cnt <= CNT_W'(MEM_LAT - 1);
      exc_code <= win_idx;
    end else if (state == FETCH) begin
      if (cnt == '0) begin
        state <= DONE;
        vec_addr <= DATA_W'(mem_rdata[7:0]);
      end else cnt <= cnt - 1'b1;
    end else state <= IDLE;
endmodule

// File: tb/tb_mem_addr_sequencer.sv
// tb_mem_addr_sequencer: three configurations checked every cycle against a cycle-number model
module tb_mem_addr_sequencer;
  logic clk = 1'b0, reset;
  logic [1:0] src_sel;
  logic [95:0] bus32;
  logic [23:0] bus8;
  logic [2:0] exc_req;
  logic [31:0] noise;
  logic [31:0] rd1, rd3, ma1, ma3, va1, va3;
  logic [7:0] rd8, ma8, va8;
  logic b1, b3, b8, v1, v3, v8;
  logic [1:0] c1, c3, c8;
  logic [31:0] h3 [2];
  int checks = 0, failures = 0, cyc = 0;
  int L [3] = '{1, 3, 1};
  int B [3] = '{253, 253, 254};
  logic [31:0] M [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_00FF};
  int st [3], cs [3];
  logic [31:0] vx [3];
  logic [2:0] pend [3];

  always #5 clk = ~clk;

  function automatic logic [7:0] rom(input logic [31:0] a);
    return a[7:0] ^ 8'hA2;
  endfunction

  // memory for u3 only returns the right byte once the address has been held three cycles
  always @(posedge clk) begin
    h3[1] <= h3[0];
    h3[0] <= ma3;
  end
  assign rd1 = {noise[31:8], rom(ma1)};
  assign rd3 = {noise[31:8], (h3[0] == ma3 && h3[1] == ma3) ? rom(ma3) : ~rom(ma3)};
  assign rd8 = rom({24'b0, ma8});

  mem_addr_sequencer u1 (.clk(clk), .reset(reset), .src_sel(src_sel), .src_bus(bus32), .exc_req(exc_req),
    .mem_rdata(rd1), .mem_addr(ma1), .busy(b1), .vec_valid(v1), .vec_addr(va1), .exc_code(c1));
  mem_addr_sequencer #(.MEM_LAT(3)) u3 (.clk(clk), .reset(reset), .src_sel(src_sel), .src_bus(bus32),
    .exc_req(exc_req), .mem_rdata(rd3), .mem_addr(ma3), .busy(b3), .vec_valid(v3), .vec_addr(va3), .exc_code(c3));
  mem_addr_sequencer #(.DATA_W(8), .VEC_BASE(254)) u8 (.clk(clk), .reset(reset), .src_sel(src_sel), .src_bus(bus8),
    .exc_req(exc_req), .mem_rdata(rd8), .mem_addr(ma8), .busy(b8), .vec_valid(v8), .vec_addr(va8), .exc_code(c8));

  function automatic logic [31:0] vaddr(input int i, input int c);
    return 32'(B[i] + c) & M[i];
  endfunction

  function automatic logic [31:0] pass(input int i);
    if (src_sel == 2'd3) return 32'h0;
    return (i == 2) ? {24'b0, bus8[int'(src_sel)*8 +: 8]} : bus32[int'(src_sel)*32 +: 32];
  endfunction

  // a fetch starting in cycle s occupies cycles s..s+L-1, pulses in s+L, idles from s+L+1
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        st[i] = -1;
        cs[i] = 0;
        vx[i] = 32'h0;
        pend[i] = 3'b0;
      end else begin
        logic [2:0] req, w;
        bit idle;
        idle = !(st[i] >= 0 && cyc >= st[i] && cyc <= st[i] + L[i]);
        w = 3'b0;
`ifdef EXC_PENDING_EN
        req = exc_req | pend[i];
`else
        req = exc_req;
`endif
        if (idle && req != 3'b0) begin
          cs[i] = req[0] ? 0 : req[1] ? 1 : 2;
          w = 3'b1 << cs[i];
          st[i] = cyc + 1;
        end else if (!idle && cyc == st[i] + L[i] - 1)
          vx[i] = {24'b0, rom(vaddr(i, cs[i]))};
        pend[i] = (pend[i] | exc_req) & ~w;
      end
    end
    cyc++;
  end

  task automatic cmp(input logic [31:0] o, input logic [31:0] e, input string n, input int i);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s u%0d cyc=%0d observed=%h expected=%h", n, i, cyc, o, e);
    end
  endtask

  task automatic check();
    for (int i = 0; i < 3; i++) begin
      logic [31:0] oma, ova, ema;
      logic ob, ov;
      logic [1:0] oc;
      bit f, d;
      oma = (i == 0) ? ma1 : (i == 1) ? ma3 : {24'b0, ma8};
      ova = (i == 0) ? va1 : (i == 1) ? va3 : {24'b0, va8};
      ob = (i == 0) ? b1 : (i == 1) ? b3 : b8;
      ov = (i == 0) ? v1 : (i == 1) ? v3 : v8;
      oc = (i == 0) ? c1 : (i == 1) ? c3 : c8;
      f = st[i] >= 0 && cyc >= st[i] && cyc < st[i] + L[i];
      d = st[i] >= 0 && cyc == st[i] + L[i];
      ema = (f || d) ? vaddr(i, cs[i]) : pass(i);
      cmp(oma, ema, "mem_addr", i);
      cmp({31'b0, ob}, {31'b0, f || d}, "busy", i);
      cmp({31'b0, ov}, {31'b0, d}, "vec_valid", i);
      cmp(ova, vx[i], "vec_addr", i);
      cmp({30'b0, oc}, 32'(cs[i]), "exc_code", i);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      #1 check();
      @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b1;
    src_sel = 2'd0;
    bus32 = '0;
    bus8 = '0;
    exc_req = 3'b0;
    noise = 32'hDEAD_BE00;
    @(negedge clk);
    step(2);
    reset = 1'b0;
    bus32 = {32'h30, 32'h20, 32'h10};
    bus8 = {8'h30, 8'h20, 8'h10};
    for (int s = 0; s < 4; s++) begin
      src_sel = 2'(s);
      step(1);
    end
    src_sel = 2'd1;
    exc_req = 3'b010;
    step(1);
    exc_req = 3'b0;
    step(4);
    exc_req = 3'b110;
    step(1);
    exc_req = 3'b0;
    step(6);
    exc_req = 3'b011;
    step(1);
    exc_req = 3'b0;
    step(6);
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    exc_req = 3'b001;
    step(1);
    exc_req = 3'b0;
    step(1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(5);
    exc_req = 3'b001;
    step(1);
    exc_req = 3'b0;
    step(1);
    exc_req = 3'b100;
    step(1);
    exc_req = 3'b0;
    step(10);
    exc_req = 3'b100;
    step(1);
    exc_req = 3'b0;
    step(6);
    repeat (400) begin
      src_sel = 2'($urandom_range(0, 3));
      bus32 = {$urandom, $urandom, $urandom};
      bus8 = 24'($urandom);
      noise = $urandom;
      exc_req = ($urandom_range(0, 4) == 0) ? 3'($urandom) : 3'b0;
      reset = ($urandom_range(0, 49) == 0);
      step(1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
